adder_seq_ctrl: RTL and testbench

Multi-cycle sequencer that reuses one N-bit adder_N instance to add two W = N*K bit operands, one N-bit chunk per clock, LSB chunk first.
- A carry register chains each chunk's carry-out into the next chunk's carry-in, time-multiplexing the chained-adder structure onto a single adder.
- Sits between a requester (start/done handshake) and the shared adder datapath; it trades latency for area in wide-word arithmetic.

---
 rtl/adder_seq_pkg.sv | 21 ++
 rtl/adder_N.sv | 16 +
 rtl/adder_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_adder_seq_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
// Shared types and helpers for the chunked sequential adder.
package adder_seq_pkg;

    // IDLE waits for a request, RUN adds one chunk per cycle,
    // DONE presents the one-cycle completion pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Width of the chunk index register; never narrower than one bit so
    // that the K=1 build still has a legal index.
    function automatic int idx_width(input int k);
        if (k <= 1) begin
            return 1;
        end
        return $clog2(k);
    endfunction

endpackage

// File: rtl/adder_N.sv
// Plain N-bit ripple adder with carry-in and carry-out.
// This is the single shared datapath element reused by adder_seq_ctrl.
module adder_N #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    // Widen every operand to N+1 bits so the carry-out falls out of the sum.
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};

endmodule

// File: rtl/adder_seq_ctrl.sv
// Multi-cycle W = N*K bit adder built from one N-bit adder_N, one chunk per
// clock, LSB chunk first. A carry register chains chunk carries.
// Optional macro ADDER_SEQ_SUB_EN adds a 'sub' port for A - B.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; SUM/Cout hold the last result
//   RUN   | busy=1; chunk idx is added and written into SUM this cycle
//   DONE  | done=1 for one cycle; a start here is accepted like in IDLE
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter  int N = 4,
    parameter  int K = 2,
    localparam int W = N * K
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         cin,
`ifdef ADDER_SEQ_SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] SUM,
    output logic         Cout
);

    localparam int            IW       = idx_width(K);
    localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

    seq_state_e    state_q, state_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q,     a_d;
    logic [W-1:0]  b_q,     b_d;
    logic [W-1:0]  sum_q,   sum_d;
    logic          cout_q,  cout_d;

    logic [N-1:0]  a_chunk;
    logic [N-1:0]  b_chunk;
    logic [N-1:0]  s_chunk;
    logic          c_chunk;

    logic [W-1:0]  b_load;
    logic          c_load;

    // Operand conditioning at capture: subtraction is A + ~B + 1.
`ifdef ADDER_SEQ_SUB_EN
    always_comb begin
        b_load = sub ? ~B : B;
        c_load = sub ? 1'b1 : cin;
    end
`else
    always_comb begin
        b_load = B;
        c_load = cin;
    end
`endif

    // Select the operand chunks addressed by the current index.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < K; k++) begin
            if (idx_q == IW'(k)) begin
                a_chunk = a_q[k*N +: N];
                b_chunk = b_q[k*N +: N];
            end
        end
    end

    adder_N #(.N(N)) u_adder (
        .a  (a_chunk),
        .b  (b_chunk),
        .ci (carry_q),
        .s  (s_chunk),
        .co (c_chunk)
    );

    // Next-state, capture and chunk write-back.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = A;
                    b_d     = b_load;
                    carry_d = c_load;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int k = 0; k < K; k++) begin
                    if (idx_q == IW'(k)) begin
                        sum_d[k*N +: N] = s_chunk;
                    end
                end
                carry_d = c_chunk;
                if (idx_q == LAST_IDX) begin
                    cout_d  = c_chunk;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign SUM  = sum_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl: fixed vectors, hand sequences for
// handshake corners, random operations against an arithmetic model, and an
// exhaustive sweep of a K=1 instance.
module tb_adder_seq_ctrl;

    localparam int N  = 4;
    localparam int K  = 2;
    localparam int W  = N * K;
    localparam int W1 = N;

    logic          clk = 1'b0;
    logic          reset;

    logic          start;
    logic [W-1:0]  A, B;
    logic          cin;
    logic          busy, done, Cout;
    logic [W-1:0]  SUM;

    logic          start1;
    logic [W1-1:0] A1, B1;
    logic          cin1;
    logic          busy1, done1, Cout1;
    logic [W1-1:0] SUM1;

`ifdef ADDER_SEQ_SUB_EN
    logic          sub;
    logic          sub1;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    adder_seq_ctrl #(.N(N), .K(K)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .cin   (cin),
`ifdef ADDER_SEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .SUM   (SUM),
        .Cout  (Cout)
    );

    adder_seq_ctrl #(.N(N), .K(1)) dut_k1 (
        .clk   (clk),
        .reset (reset),
        .start (start1),
        .A     (A1),
        .B     (B1),
        .cin   (cin1),
`ifdef ADDER_SEQ_SUB_EN
        .sub   (sub1),
`endif
        .busy  (busy1),
        .done  (done1),
        .SUM   (SUM1),
        .Cout  (Cout1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic       s;
        logic [7:0] sum;
        logic       co;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the (W+1)-bit result of the requested arithmetic.
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic c, input logic s);
        int r;
        if (s) begin
            r = (int'(a) - int'(b)) & 255;
            return {(a >= b), r[7:0]};
        end
        r = int'(a) + int'(b) + int'(c);
        return r[8:0];
    endfunction

    function automatic logic rand_sub();
`ifdef ADDER_SEQ_SUB_EN
        return 1'($urandom_range(0, 1));
`else
        return 1'b0;
`endif
    endfunction

    // One isolated operation: pulse start, scramble inputs after acceptance,
    // wait (bounded) for done, check latency, result and pulse width.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic s, input logic [7:0] esum, input logic eco,
                          input string name);
        int cnt;
        logic got;
        @(negedge clk);
        A = a; B = b; cin = c; start = 1'b1;
`ifdef ADDER_SEQ_SUB_EN
        sub = s;
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); cin = 1'($urandom_range(0, 1));
`ifdef ADDER_SEQ_SUB_EN
        sub = ~s;
`endif
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 10) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) check({name, "_busy"}, 32'(busy), 32'd1);
            if (done) got = 1'b1;
        end
        check({name, "_latency"}, 32'(cnt), 32'(K + 1));
        check({name, "_sum"}, 32'(SUM), 32'(esum));
        check({name, "_cout"}, 32'(Cout), 32'(eco));
        @(negedge clk);
        check({name, "_donepulse"}, 32'({busy, done}), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] e;
        logic [7:0] ra, rb;
        logic       rc, rs;
        int         cnt;

        reset = 1'b1; start = 1'b0; A = '0; B = '0; cin = 1'b0;
        start1 = 1'b0; A1 = '0; B1 = '0; cin1 = 1'b0;
`ifdef ADDER_SEQ_SUB_EN
        sub = 1'b0; sub1 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'({busy, done, Cout, SUM}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        tbl.push_back('{8'h5A, 8'hC3, 1'b0, 1'b0, 8'h1D, 1'b1});
        tbl.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
        tbl.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0});
        tbl.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
        tbl.push_back('{8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0});
        tbl.push_back('{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0});
        tbl.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
`ifdef ADDER_SEQ_SUB_EN
        tbl.push_back('{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1});
        tbl.push_back('{8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0});
        tbl.push_back('{8'h55, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1});
        tbl.push_back('{8'h00, 8'hFF, 1'b1, 1'b1, 8'h01, 1'b0});
`endif
        foreach (tbl[i]) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s, tbl[i].sum, tbl[i].co,
                   $sformatf("tbl%0d", i));
        end

        // start re-asserted while RUN must be ignored.
        @(negedge clk);
        A = 8'h5A; B = 8'hC3; cin = 1'b0; start = 1'b1;
`ifdef ADDER_SEQ_SUB_EN
        sub = 1'b0;
`endif
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        A = 8'h11; B = 8'h22; start = 1'b1;
        @(negedge clk);
        check("ignore_still_busy", 32'({busy, done}), 32'b10);
        @(negedge clk);
        check("ignore_done", 32'(done), 32'd1);
        check("ignore_sum", 32'({Cout, SUM}), 32'h11D);
        start = 1'b0;
        @(negedge clk);
        check("ignore_idle", 32'({busy, done}), 32'd0);
        check("ignore_hold", 32'({Cout, SUM}), 32'h11D);

        // Back-to-back: start held through DONE starts the next op at once.
        @(negedge clk);
        A = 8'hFF; B = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        check("b2b_busy0", 32'(busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("b2b_done1", 32'(done), 32'd1);
        check("b2b_res1", 32'({Cout, SUM}), 32'h100);
        A = 8'h12; B = 8'h34; cin = 1'b1;
        @(negedge clk);
        check("b2b_busy_again", 32'({busy, done}), 32'b10);
        start = 1'b0;
        @(negedge clk);
        check("b2b_busy_mid", 32'({busy, done}), 32'b10);
        @(negedge clk);
        check("b2b_done2", 32'(done), 32'd1);
        check("b2b_res2", 32'({Cout, SUM}), 32'h047);

        // Asynchronous reset between edges in the middle of RUN.
        run_op(8'h5A, 8'hC3, 1'b0, 1'b0, 8'h1D, 1'b1, "pre_reset");
        @(negedge clk);
        A = 8'hFF; B = 8'hFF; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("rst_pre_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_async", 32'({busy, done, Cout, SUM}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_done", 32'({busy, done, Cout, SUM}), 32'd0);
        end
        run_op(8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, "post_reset");

        // Random isolated operations.
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rc = 1'($urandom_range(0, 1)); rs = rand_sub();
            e = model(ra, rb, rc, rs);
            run_op(ra, rb, rc, rs, e[7:0], e[8], "rand");
        end

        // Random back-to-back stream with start held high.
        @(negedge clk);
        ra = 8'($urandom); rb = 8'($urandom);
        rc = 1'($urandom_range(0, 1)); rs = rand_sub();
        A = ra; B = rb; cin = rc; start = 1'b1;
`ifdef ADDER_SEQ_SUB_EN
        sub = rs;
`endif
        e = model(ra, rb, rc, rs);
        for (int i = 0; i < 300; i++) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (!done && cnt < 10);
            check("stream_latency", 32'(cnt), 32'(K + 1));
            check("stream_result", 32'({Cout, SUM}), 32'(e));
            if (i < 299) begin
                ra = 8'($urandom); rb = 8'($urandom);
                rc = 1'($urandom_range(0, 1)); rs = rand_sub();
                A = ra; B = rb; cin = rc;
`ifdef ADDER_SEQ_SUB_EN
                sub = rs;
`endif
                e = model(ra, rb, rc, rs);
            end else begin
                start = 1'b0;
            end
        end

        // Exhaustive K=1 sweep, streamed back to back.
        @(negedge clk);
        start1 = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    A1 = 4'(a); B1 = 4'(b); cin1 = 1'(c);
                    cnt = 0;
                    do begin
                        @(negedge clk);
                        cnt++;
                    end while (!done1 && cnt < 10);
                    check("k1_latency", 32'(cnt), 32'd2);
                    check("k1_result", 32'({Cout1, SUM1}), 32'(a + b + c));
                end
            end
        end
        start1 = 1'b0;
        @(negedge clk);
        check("k1_idle", 32'({busy1, done1}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
